// File: rtl/moving_sprite_writer.sv
// Moves the Capman sprite by one pixel per frame.
// After each end-of-frame pulse it reads the sprite position from memory and
// probes the two tiles along the leading edge of the move. If both tiles are
// empty it writes back the new position and direction sprite. Every sequence
// ends by clearing the end-of-frame flag word.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for frameDone; addr_a parked on the X word
// RD_X     | X address on the bus
// RD_Y     | X data returned (captured); Y address on the bus
// LAT_Y    | Y data returned (captured)
// CALC     | pick direction, bounds-check target, issue first probe
// RD_T0    | first probe address on the bus
// RD_T1    | first tile ID returned (captured); second probe on the bus
// CHK      | second tile ID on read_a; wall test
// WR_X     | writing new X
// WR_Y     | writing new Y
// WR_DIR   | writing direction sprite ID
// CLR_FLAG | writing 0 to the end-of-frame flag word
module moving_sprite_writer #(
   parameter int          DATA_WIDTH      = 16,
   parameter int          ADDR_WIDTH      = 16,
   parameter logic [15:0] CAP_X_ADDR      = 16'h1C30,
   parameter logic [15:0] CAP_Y_ADDR      = 16'h1C31,
   parameter logic [15:0] CAP_DIR_ADDR    = 16'h1C32,
   parameter logic [15:0] FRAME_FLAG_ADDR = 16'h1DD5,
   parameter logic [15:0] SPRITE_ID_BASE  = 16'h1000,
   parameter logic [15:0] WALL_MIN_ID     = 16'd1,
   parameter logic [15:0] ID_UP           = 16'd21,
   parameter logic [15:0] ID_DOWN         = 16'd22,
   parameter logic [15:0] ID_LEFT         = 16'd23,
   parameter logic [15:0] ID_RIGHT        = 16'd24
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  frameDone,
   input  logic [3:0]            btn,
   input  logic [DATA_WIDTH-1:0] read_a,
   output logic [ADDR_WIDTH-1:0] addr_a,
   output logic [DATA_WIDTH-1:0] data_a,
   output logic                  write_a,
   output logic                  busy
);

   typedef enum logic [3:0] {
      IDLE, RD_X, RD_Y, LAT_Y, CALC, RD_T0, RD_T1, CHK,
      WR_X, WR_Y, WR_DIR, CLR_FLAG
   } state_t;

   state_t                state;
   logic [3:0]            btn_q;
   logic [9:0]            pos_x;
   logic [8:0]            pos_y;
   logic [9:0]            new_x;
   logic [8:0]            new_y;
   logic [DATA_WIDTH-1:0] dir_q;
   logic [DATA_WIDTH-1:0] tile0;

   logic                  move_req;
   logic                  move_ok;
   logic [10:0]           tgt_x;
   logic [10:0]           tgt_y;
   logic [5:0]            col0, col1;
   logic [4:0]            row0, row1;
   logic [ADDR_WIDTH-1:0] probe0, probe1;
   logic [DATA_WIDTH-1:0] dir_code;

   // Tile-map word for a tile column/row; 40 tiles per row, wraps at 16 bits.
   function automatic logic [ADDR_WIDTH-1:0] tile_addr(input logic [5:0] col,
                                                      input logic [4:0] row);
      logic [15:0] a;
      a = SPRITE_ID_BASE + {10'd0, col} + ({11'd0, row} * 16'd40);
      return ADDR_WIDTH'(a);
   endfunction

   // Direction decode (up > down > left > right), target position and probe tiles.
   // Wrap-around at 0 lands far above the bounds, so one compare covers both edges.
   always_comb begin
      move_req = 1'b1;
      tgt_x    = {1'b0, pos_x};
      tgt_y    = {2'b0, pos_y};
      col0     = 6'(pos_x >> 4);
      col1     = col0;
      row0     = 5'(pos_y >> 4);
      row1     = row0;
      dir_code = '0;
      if (btn_q[3]) begin
         tgt_y    = {2'b0, pos_y} - 11'd1;
         col1     = 6'((pos_x + 10'd15) >> 4);
         row0     = 5'((pos_y - 9'd1) >> 4);
         row1     = row0;
         dir_code = DATA_WIDTH'(ID_UP);
      end else if (btn_q[2]) begin
         tgt_y    = {2'b0, pos_y} + 11'd1;
         col1     = 6'((pos_x + 10'd15) >> 4);
         row0     = 5'((pos_y + 9'd16) >> 4);
         row1     = row0;
         dir_code = DATA_WIDTH'(ID_DOWN);
      end else if (btn_q[1]) begin
         tgt_x    = {1'b0, pos_x} - 11'd1;
         col0     = 6'((pos_x - 10'd1) >> 4);
         col1     = col0;
         row1     = 5'((pos_y + 9'd15) >> 4);
         dir_code = DATA_WIDTH'(ID_LEFT);
      end else if (btn_q[0]) begin
         tgt_x    = {1'b0, pos_x} + 11'd1;
         col0     = 6'((pos_x + 10'd16) >> 4);
         col1     = col0;
         row1     = 5'((pos_y + 9'd15) >> 4);
         dir_code = DATA_WIDTH'(ID_RIGHT);
      end else begin
         move_req = 1'b0;
      end
      move_ok = move_req && (tgt_x <= 11'd624) && (tgt_y <= 11'd464);
      probe0  = tile_addr(col0, row0);
      probe1  = tile_addr(col1, row1);
   end

   // Sequencer with registered bus outputs; addr_a is set on entry to each state.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state   <= IDLE;
         addr_a  <= ADDR_WIDTH'(CAP_X_ADDR);
         data_a  <= '0;
         write_a <= 1'b0;
         busy    <= 1'b0;
         btn_q   <= '0;
         pos_x   <= '0;
         pos_y   <= '0;
         new_x   <= '0;
         new_y   <= '0;
         dir_q   <= '0;
         tile0   <= '0;
      end else begin
         case (state)
            IDLE: begin
               write_a <= 1'b0;
               if (frameDone) begin
                  btn_q  <= btn;
                  busy   <= 1'b1;
                  addr_a <= ADDR_WIDTH'(CAP_X_ADDR);
                  state  <= RD_X;
               end
            end
            RD_X: begin
               addr_a <= ADDR_WIDTH'(CAP_Y_ADDR);
               state  <= RD_Y;
            end
            RD_Y: begin
               pos_x <= read_a[9:0];
               state <= LAT_Y;
            end
            LAT_Y: begin
               pos_y <= read_a[8:0];
               state <= CALC;
            end
            CALC: begin
               if (move_ok) begin
                  addr_a <= probe0;
                  new_x  <= tgt_x[9:0];
                  new_y  <= tgt_y[8:0];
                  dir_q  <= dir_code;
                  state  <= RD_T0;
               end else begin
                  addr_a  <= ADDR_WIDTH'(FRAME_FLAG_ADDR);
                  data_a  <= '0;
                  write_a <= 1'b1;
                  state   <= CLR_FLAG;
               end
            end
            RD_T0: begin
               addr_a <= probe1;
               state  <= RD_T1;
            end
            RD_T1: begin
               tile0 <= read_a;
               state <= CHK;
            end
            CHK: begin
               write_a <= 1'b1;
               if ((tile0 >= DATA_WIDTH'(WALL_MIN_ID)) ||
                   (read_a >= DATA_WIDTH'(WALL_MIN_ID))) begin
                  addr_a <= ADDR_WIDTH'(FRAME_FLAG_ADDR);
                  data_a <= '0;
                  state  <= CLR_FLAG;
               end else begin
                  addr_a <= ADDR_WIDTH'(CAP_X_ADDR);
                  data_a <= DATA_WIDTH'(new_x);
                  state  <= WR_X;
               end
            end
            WR_X: begin
               addr_a <= ADDR_WIDTH'(CAP_Y_ADDR);
               data_a <= DATA_WIDTH'(new_y);
               state  <= WR_Y;
            end
            WR_Y: begin
               addr_a <= ADDR_WIDTH'(CAP_DIR_ADDR);
               data_a <= dir_q;
               state  <= WR_DIR;
            end
            WR_DIR: begin
               addr_a <= ADDR_WIDTH'(FRAME_FLAG_ADDR);
               data_a <= '0;
               state  <= CLR_FLAG;
            end
            CLR_FLAG: begin
               write_a <= 1'b0;
               busy    <= 1'b0;
               addr_a  <= ADDR_WIDTH'(CAP_X_ADDR);
               state   <= IDLE;
            end
            default: begin
               write_a <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_moving_sprite_writer.sv
// Bench for moving_sprite_writer: behavioural memory, a reference model of one
// frame's expected writes and latency, and one negedge compare process.
module tb_moving_sprite_writer;

   localparam int CAP_X = 'h1C30;
   localparam int CAP_Y = 'h1C31;
   localparam int CAP_D = 'h1C32;
   localparam int FLAG  = 'h1DD5;

   logic        clk = 1'b0;
   logic        clear = 1'b0;
   logic        frameDone = 1'b0;
   logic [3:0]  btn = 4'b0000;
   logic [15:0] read_a;
   logic [15:0] addr_a;
   logic [15:0] data_a;
   logic        write_a;
   logic        busy;

   logic [15:0] mem [0:65535];
   logic        poke_en = 1'b0;
   logic [15:0] poke_addr = 16'd0;
   logic [15:0] poke_data = 16'd0;

   int passed = 0;
   int total  = 0;

   typedef struct {int addr; int data;} wr_t;
   wr_t exp_q[$];
   int  exp_lat;
   int  exp_p0;
   int  exp_p1;
   bit  exp_tiles;
   bit  active = 1'b0;
   bit  done = 1'b0;
   int  cyc;
   bit  seen0, seen1, tile_any;
   int  m_nx, m_ny, m_dir, m_lat;

   moving_sprite_writer dut (
      .clk       (clk),
      .clear     (clear),
      .frameDone (frameDone),
      .btn       (btn),
      .read_a    (read_a),
      .addr_a    (addr_a),
      .data_a    (data_a),
      .write_a   (write_a),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Synchronous memory: read data valid the cycle after the address.
   always @(posedge clk) begin
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (write_a) mem[addr_a] <= data_a;
      read_a <= mem[addr_a];
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Compare process: tracks one frame sequence from the accepted frameDone.
   always @(negedge clk) begin
      if (!clear) begin
         active = 1'b0;
         exp_q.delete();
      end else if (!active) begin
         if (busy || write_a) begin
            total++;
            $display("FAIL idle_activity: busy=%0b write_a=%0b expected 0 0", busy, write_a);
         end
         if (frameDone) begin
            active = 1'b1; cyc = 0; seen0 = 0; seen1 = 0; tile_any = 0;
         end
      end else begin
         cyc++;
         if (cyc == 1) chk("rd_x_addr", int'(addr_a), CAP_X);
         if (cyc == 2) chk("rd_y_addr", int'(addr_a), CAP_Y);
         if (busy && !write_a) begin
            if (int'(addr_a) == exp_p0) seen0 = 1;
            if (int'(addr_a) == exp_p1) seen1 = 1;
            if (addr_a >= 16'h1000 && addr_a < 16'h1000 + 16'd1200) tile_any = 1;
         end
         if (write_a) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL stray_write: addr=%0h data=%0d expected no write", addr_a, data_a);
            end else begin
               wr_t w;
               w = exp_q.pop_front();
               chk("write_addr", int'(addr_a), w.addr);
               chk("write_data", int'(data_a), w.data);
            end
         end
         if (!busy) begin
            active = 1'b0;
            done = 1'b1;
            chk("latency", cyc, exp_lat);
            chk("writes_left", exp_q.size(), 0);
            if (exp_tiles) chk("probes_read", int'(seen0 && seen1), 1);
            else chk("no_tile_read", int'(tile_any), 0);
         end else if (cyc > 40) begin
            total++;
            $display("FAIL busy_timeout: cycles=%0d expected at most 12", cyc);
            active = 1'b0;
            done = 1'b1;
         end
      end
   end

   // Reference model: destination box, leading-edge corners, expected writes.
   task automatic model(input int x, input int y, input logic [3:0] b);
      int  nx, ny, px0, py0, px1, py1;
      bit  inb, wall;
      nx = x; ny = y; m_dir = 0;
      if (b[3])      begin ny = y - 1; m_dir = 21; end
      else if (b[2]) begin ny = y + 1; m_dir = 22; end
      else if (b[1]) begin nx = x - 1; m_dir = 23; end
      else if (b[0]) begin nx = x + 1; m_dir = 24; end
      px0 = nx; py0 = ny; px1 = nx; py1 = ny;
      case (m_dir)
         21: begin px1 = nx + 15; end
         22: begin py0 = ny + 15; py1 = ny + 15; px1 = nx + 15; end
         23: begin py1 = ny + 15; end
         24: begin px0 = nx + 15; px1 = nx + 15; py1 = ny + 15; end
         default: ;
      endcase
      inb = (m_dir != 0) && nx >= 0 && nx <= 624 && ny >= 0 && ny <= 464;
      exp_p0 = -1; exp_p1 = -1; wall = 0;
      if (inb) begin
         exp_p0 = ('h1000 + px0 / 16 + (py0 / 16) * 40) & 'hFFFF;
         exp_p1 = ('h1000 + px1 / 16 + (py1 / 16) * 40) & 'hFFFF;
         wall = (int'(mem[exp_p0]) >= 1) || (int'(mem[exp_p1]) >= 1);
      end
      m_lat = !inb ? 6 : (wall ? 9 : 12);
      m_nx = nx; m_ny = ny;
      exp_tiles = inb;
      exp_lat = m_lat;
      exp_q.delete();
      if (inb && !wall) begin
         exp_q.push_back('{CAP_X, nx});
         exp_q.push_back('{CAP_Y, ny});
         exp_q.push_back('{CAP_D, m_dir});
      end
      exp_q.push_back('{FLAG, 0});
   endtask

   task automatic poke(input int a, input int d);
      poke_addr = 16'(a); poke_data = 16'(d); poke_en = 1'b1;
      @(posedge clk); #1 poke_en = 1'b0;
   endtask

   task automatic pulse_fd();
      frameDone = 1'b1;
      @(posedge clk); #1 frameDone = 1'b0;
   endtask

   task automatic run(input string nm, input int x, input int y,
                      input logic [3:0] b, input bit dbl);
      bit busy_seen;
      poke(CAP_X, x); poke(CAP_Y, y); poke(FLAG, 1);
      btn = b;
      model(x, y, b);
      done = 1'b0;
      pulse_fd();
      if (dbl) begin
         repeat (2) @(posedge clk);
         #1 pulse_fd();
      end
      for (int i = 0; i < 60 && !done; i++) @(posedge clk);
      #1;
      if (!done) chk({nm, "_done"}, 0, 1);
      busy_seen = 0;
      repeat (dbl ? 15 : 3) begin
         @(negedge clk);
         if (busy) busy_seen = 1;
      end
      chk({nm, "_stays_idle"}, int'(busy_seen), 0);
      chk({nm, "_flag_cleared"}, int'(mem[FLAG]), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      bit found;
      #12;
      chk("rst_addr", int'(addr_a), CAP_X);
      chk("rst_data", int'(data_a), 0);
      chk("rst_write", int'(write_a), 0);
      chk("rst_busy", int'(busy), 0);
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1;

      run("no_move", 100, 64, 4'b0000, 0);
      chk("pin_lat_nomove", m_lat, 6);

      run("right_free", 100, 64, 4'b0001, 0);
      chk("pin_probe_right", exp_p0, 'h10A7);
      chk("pin_nx_right", m_nx, 101);
      chk("pin_lat_move", m_lat, 12);
      chk("mem_x_right", int'(mem[CAP_X]), 101);

      poke('h10A7, 5);
      run("right_wall", 100, 64, 4'b0001, 0);
      chk("pin_lat_wall", m_lat, 9);
      poke('h10A7, 0);

      run("left_edge", 0, 64, 4'b0010, 0);
      run("up_right", 32, 32, 4'b1001, 0);
      chk("pin_ny_up", m_ny, 31);
      chk("pin_dir_up", m_dir, 21);
      chk("mem_y_up", int'(mem[CAP_Y]), 31);

      run("down_edge_blk", 10, 464, 4'b0100, 0);
      run("down_edge_ok", 10, 463, 4'b0100, 0);
      run("right_edge_blk", 624, 100, 4'b0001, 0);
      run("right_edge_ok", 623, 100, 4'b0001, 0);

      poke('h10CF, 3);
      run("down_wall_t1", 100, 64, 4'b0100, 0);
      chk("pin_probe1_down", exp_p1, 'h10CF);
      poke('h10CF, 0);

      run("left_free", 100, 64, 4'b0010, 0);
      run("dbl_frame", 100, 64, 4'b0001, 1);

      // Reset while WR_X is driving the bus.
      poke(CAP_X, 100); poke(CAP_Y, 64); poke(FLAG, 1);
      btn = 4'b0001;
      model(100, 64, 4'b0001);
      done = 1'b0;
      pulse_fd();
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (write_a) found = 1;
      end
      chk("rst_wr_x_reached", int'(found), 1);
      clear = 1'b0;
      #1;
      chk("rst_mid_write", int'(write_a), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_addr", int'(addr_a), CAP_X);
      chk("rst_mid_data", int'(data_a), 0);
      @(posedge clk); @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1;
      chk("rst_no_x_write", int'(mem[CAP_X]), 100);
      chk("rst_no_flag_write", int'(mem[FLAG]), 1);
      run("after_reset", 100, 64, 4'b0001, 0);
      chk("mem_x_after_reset", int'(mem[CAP_X]), 101);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
